// File: rtl/inst_rom_loader_if.sv
// Byte-stream and instruction-ROM write port of the boot loader.
// The loader side uses the slave modport: it consumes the byte stream and
// drives the ROM write strobe. The master modport is the environment side.
interface inst_rom_loader_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, rom_we, rom_addr, rom_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, rom_we, rom_addr, rom_wdata
   );
endinterface

// File: rtl/inst_rom_loader.sv
// Boot-time instruction ROM loader. Reads a 32-bit big-endian word count,
// then that many big-endian instruction words, writes them to consecutive
// ROM word addresses and finally releases the CPU reset after a short hold.
module inst_rom_loader #(
   parameter int unsigned ADDR_W        = 17,
   parameter int unsigned RELEASE_DELAY = 4
) (
   input  logic               clk,
   input  logic               rst,
   inst_rom_loader_if.slave   bus,
   output logic               cpu_rst,
   output logic               load_done,
   output logic               load_err
);

   typedef enum logic [2:0] {BOOT, HDR, DATA, HOLD, RUN, ERR} state_e;

   // One past the highest word address: largest legal word count.
   localparam logic [32:0]       CAPACITY = 33'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [7:0]        DELAY_LAST = 8'(RELEASE_DELAY);

   state_e            state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       shift_q, shift_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [7:0]        delay_q, delay_d;
   logic              byte_ready_q, byte_ready_d;
   logic              rom_we_q, rom_we_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [31:0]       rom_wdata_q, rom_wdata_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;

   logic              xfer;
   logic [31:0]       word;

   assign xfer = bus.byte_valid && byte_ready_q;
   // The incoming byte completes the big-endian word / header value.
   assign word = {shift_q, bus.byte_data};

   // Next-state and next-output logic for the load sequence.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      state_d     = state_q;
      lane_d      = lane_q;
      shift_d     = shift_q;
      word_cnt_d  = word_cnt_q;
      n_d         = n_q;
      delay_d     = delay_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;

      unique case (state_q)
         BOOT: begin
            // The lane counter marks the single idle BOOT cycle so byte_ready
            // rises on the second edge after reset release.
            if (lane_q == 2'd0) begin
               lane_d = 2'd1;
            end else begin
               state_d = HDR;
               lane_d  = 2'd0;
            end
         end

         HDR: begin
            if (xfer) begin
               shift_d = word[23:0];
               lane_d  = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  lane_d  = 2'd0;
                  delay_d = 8'd0;
                  if (word == 32'd0) begin
                     state_d = HOLD;
                  end else if ({1'b0, word} > CAPACITY) begin
                     state_d = ERR;
                  end else begin
                     state_d = DATA;
                     n_d     = word[ADDR_W:0];
                  end
               end
            end
         end

         DATA: begin
            // Leave while the N-th strobe is on the port; a byte offered in
            // that cycle is dropped since the image is already complete.
            if (rom_we_q && (word_cnt_q == n_q)) begin
               state_d = HOLD;
               lane_d  = 2'd0;
               delay_d = 8'd0;
            end else if (xfer) begin
               shift_d = word[23:0];
               lane_d  = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = word_cnt_q[ADDR_W-1:0];
                  rom_wdata_d = word;
                  word_cnt_d  = word_cnt_q + CNT_ONE;
               end
            end
         end

         HOLD: begin
            delay_d = delay_q + 8'd1;
            if ((delay_q + 8'd1) == DELAY_LAST) begin
               state_d = RUN;
               lane_d  = 2'd0;
            end
         end

         RUN, ERR: ;

         default: state_d = BOOT;
      endcase

      // Status outputs are registered from the state being entered.
      byte_ready_d = (state_d == HDR) || (state_d == DATA);
      cpu_rst_d    = (state_d != RUN);
      load_done_d  = (state_d == RUN);
      load_err_d   = (state_d == ERR);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= BOOT;
         lane_q       <= 2'd0;
         shift_q      <= 24'd0;
         word_cnt_q   <= '0;
         n_q          <= '0;
         delay_q      <= 8'd0;
         byte_ready_q <= 1'b0;
         rom_we_q     <= 1'b0;
         rom_addr_q   <= '0;
         rom_wdata_q  <= 32'd0;
         cpu_rst_q    <= 1'b1;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         lane_q       <= lane_d;
         shift_q      <= shift_d;
         word_cnt_q   <= word_cnt_d;
         n_q          <= n_d;
         delay_q      <= delay_d;
         byte_ready_q <= byte_ready_d;
         rom_we_q     <= rom_we_d;
         rom_addr_q   <= rom_addr_d;
         rom_wdata_q  <= rom_wdata_d;
         cpu_rst_q    <= cpu_rst_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.rom_we     = rom_we_q;
   assign bus.rom_addr   = rom_addr_q;
   assign bus.rom_wdata  = rom_wdata_q;
   assign cpu_rst        = cpu_rst_q;
   assign load_done      = load_done_q;
   assign load_err       = load_err_q;

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-time writer for the instruction memory of the minimum SOPC. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and writes them to consecutive word addresses of the instruction ROM. The CPU is held in reset throughout. Once the image is complete, the loader releases the CPU reset. It sits between an external byte source (UART receiver or debug port) and the inst_rom write port, and drives the CPU core's reset input.

## Interface
Parameters:
- ADDR_W, 17, width of the instruction-ROM word address; capacity is 2^ADDR_W words
- RELEASE_DELAY, 4, cycles spent in HOLD between the last ROM write and CPU reset release; legal range 1..255

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset; forces the reset values below immediately
- byte_valid  in  1  source presents a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte; registered
- rom_we  out  1  one-cycle write strobe to inst_rom
- rom_addr  out  ADDR_W  word address of the write
- rom_wdata  out  32  instruction word
- cpu_rst  out  1  active-high reset to the CPU core (RstEnable = 1)
- load_done  out  1  image loaded and CPU released; sticky until rst
- load_err  out  1  header count exceeds capacity; sticky until rst

## Operation
- Byte transfer occurs on a rising edge where byte_valid && byte_ready; byte_data is ignored otherwise.
- Stream format:
  - 4 header bytes give word count N as a 32-bit big-endian value (first byte = N[31:24]).
  - Then 4*N image bytes follow. Within each word, the first byte goes to bits 31:24 and the fourth byte to bits 7:0.
- States:
  - BOOT: the single state after reset.
  - HDR: collect 4 header bytes.
  - DATA: collect image words.
  - HOLD: count RELEASE_DELAY cycles.
  - RUN: CPU running.
  - ERR: fault, exits only on rst.
- Transitions:
  - BOOT -> HDR after 1 cycle.
  - HDR -> HOLD if N == 0.
  - HDR -> ERR if N > 2^ADDR_W.
  - HDR -> DATA otherwise.
  - DATA -> HOLD on the cycle of the N-th word's write strobe.
  - HOLD -> RUN when the delay counter reaches RELEASE_DELAY.
- byte_ready is 1 only in HDR and DATA. It stays 1 during a write strobe, so there is no bubble between words.
- Word index counter:
  - Width ADDR_W+1.
  - Starts at 0 and increments after each write.
  - rom_addr = counter[ADDR_W-1:0]; the write order is 0,1,...,N-1.
  - N == 2^ADDR_W is legal and fills the ROM exactly, ending at address 2^ADDR_W-1.
  - The counter never wraps.
- The byte-lane counter (0..3) resets to 0 at each state entry.
- Partial word or stalled source: the loader waits indefinitely. There is no timeout.
- In RUN and ERR all further bytes are refused (byte_ready = 0).
- cpu_rst = 1 in every state except RUN.
- load_done = 1 only in RUN.
- load_err = 1 only in ERR.

## Timing
- Reset values (while rst = 0):
  - byte_ready = 0, rom_we = 0, rom_addr = 0, rom_wdata = 0.
  - cpu_rst = 1, load_done = 0, load_err = 0.
  - state = BOOT, all counters 0.
- byte_ready first rises at the second rising edge after rst deasserts (BOOT occupies one cycle).
- Write latency:
  - The 4th byte of a word is accepted at edge k.
  - rom_we = 1, with rom_addr/rom_wdata valid, from edge k to edge k+1.
  - rom_we then drops unless another word completes at edge k+1, which is impossible because a word needs at least 4 edges.
- Release latency:
  - The last write strobe is high during cycle k..k+1, and HOLD is entered at edge k+1.
  - cpu_rst falls and load_done rises together at edge k+1+RELEASE_DELAY.
- N == 0:
  - The 4th header byte is accepted at edge h, and HOLD is entered at edge h.
  - Release happens at edge h+RELEASE_DELAY.
  - No rom_we pulse is issued.
- ERR is entered at the edge accepting the 4th header byte. byte_ready and cpu_rst are both registered from that edge: byte_ready = 0, cpu_rst = 1.
- Reset mid-operation:
  - All outputs return to reset values asynchronously, and the in-progress word is discarded.
  - ROM contents already written are not erased.
  - After rst deasserts, the stream restarts with a fresh header.

## Test plan
- Header 00 00 00 02, then bytes 34 01 00 10, 34 02 00 20, back-to-back valid:
  - rom_we pulses twice, (addr 0, 0x34010010) then (addr 1, 0x34020020).
  - cpu_rst falls exactly RELEASE_DELAY+1 edges after the final byte; load_done = 1.
- Same image with byte_valid low for 3 random cycles between bytes: identical writes, no spurious rom_we, byte_ready stays 1 until HOLD.
- Header 00 00 00 00: no rom_we pulse; cpu_rst falls RELEASE_DELAY edges after the 4th header byte.
- ADDR_W = 4, header 00 00 00 11 (17 words): load_err = 1 and byte_ready = 0 after the 4th header byte; cpu_rst stays 1 for 100 cycles despite further valid bytes.
- ADDR_W = 4, N = 16: the last write is addr 15, and the design proceeds to RUN.
- Drive rst = 0 mid-word (after 2 of 4 bytes of word 1), then release and send a new 1-word image 0xDEADBEEF:
  - Outputs show reset values during rst.
  - The single write is (addr 0, 0xDEADBEEF), with no trace of the aborted word.
